pipes_sumsquare_ctrl: RTL and testbench

//  Sequencer for the pipes_sumsquare lane array. It packs a ready/valid stream of
//  32-bit operand pairs into WIDTH-lane groups and holds them stable while the

---
 rtl/pipes_sumsquare_ctrl_if.sv | 31 +++
 rtl/pipes_sumsquare_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipes_sumsquare_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipes_sumsquare_ctrl_if.sv
// Handshake and datapath bundle between the sumsquare sequencer and its neighbours.
// master = the controller; slave = operand source, lane array and result consumer.
interface pipes_sumsquare_ctrl_if #(
    parameter int WIDTH    = 16,
    parameter int VARWIDTH = 32,
    parameter int CW       = $clog2(WIDTH + 1)
);
    logic                      in_valid;
    logic                      in_ready;
    logic [VARWIDTH-1:0]       in_a;
    logic [VARWIDTH-1:0]       in_b;
    logic                      in_last;
    logic                      pipe_EN;
    logic [VARWIDTH*WIDTH-1:0] pipe_vals0;
    logic [VARWIDTH*WIDTH-1:0] pipe_vals1;
    logic [VARWIDTH*WIDTH-1:0] pipe_out;
    logic                      out_valid;
    logic                      out_ready;
    logic [VARWIDTH*WIDTH-1:0] out_data;
    logic [CW-1:0]             out_count;

    modport master (
        input  in_valid, in_a, in_b, in_last, pipe_out, out_ready,
        output in_ready, pipe_EN, pipe_vals0, pipe_vals1, out_valid, out_data, out_count
    );

    modport slave (
        output in_valid, in_a, in_b, in_last, pipe_out, out_ready,
        input  in_ready, pipe_EN, pipe_vals0, pipe_vals1, out_valid, out_data, out_count
    );
endinterface

// File: rtl/pipes_sumsquare_ctrl.sv
// Sequencer for the pipes_sumsquare lane array: pack operand pairs, settle, fire EN, return results.
// Optional SUMSQ_CTRL_PERF_EN adds saturating perf_groups / perf_stall counters.
module pipes_sumsquare_ctrl #(
    parameter int WIDTH    = 16,
    parameter int VARWIDTH = 32,
    parameter int SETTLE   = 4,
    parameter int CW       = $clog2(WIDTH + 1)
) (
    input logic                    CLK,
    input logic                    RST,
    pipes_sumsquare_ctrl_if.master bus
`ifdef SUMSQ_CTRL_PERF_EN
    ,
    output logic [31:0]            perf_groups,
    output logic [31:0]            perf_stall
`endif
);
    localparam int SCW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {S_FILL, S_SETTLE, S_FIRE, S_OUT} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  ptr_q, ptr_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [SCW-1:0]                 cnt_q, cnt_d;
    logic [WIDTH-1:0][VARWIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0][VARWIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0][VARWIDTH-1:0] od_q, od_d;
    logic [CW-1:0]                  oc_q, oc_d;
    logic                           en_q, en_d;
    logic                           ov_q, ov_d;
    logic                           ir_q, ir_d;
    logic                           beat;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        od_d    = od_q;
        oc_d    = oc_q;
        en_d    = en_q;
        ov_d    = ov_q;
        beat    = bus.in_valid & ir_q;

        unique case (state_q)
            S_FILL: begin
                if (beat) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (ptr_q == CW'(i)) begin
                            a_d[i] = bus.in_a;
                            b_d[i] = bus.in_b;
                        end
                    end
                    ptr_d = ptr_q + CW'(1);
                    if (ptr_q == CW'(WIDTH - 1) || bus.in_last) begin
                        count_d = ptr_q + CW'(1);
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                // First settle cycle zeroes unused lanes; the SETTLE hold starts after that.
                if (cnt_q == '0) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (CW'(i) >= count_q) begin
                            a_d[i] = '0;
                            b_d[i] = '0;
                        end
                    end
                end
                if (cnt_q == SCW'(SETTLE)) begin
                    state_d = S_FIRE;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + SCW'(1);
                end
            end
            S_FIRE: begin
                od_d    = bus.pipe_out;
                oc_d    = count_q;
                ov_d    = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    ov_d    = 1'b0;
                    en_d    = 1'b0;
                    ptr_d   = '0;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase

        ir_d = (state_d == S_FILL);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FILL;
            ptr_q   <= '0;
            count_q <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            od_q    <= '0;
            oc_q    <= '0;
            en_q    <= 1'b0;
            ov_q    <= 1'b0;
            ir_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            od_q    <= od_d;
            oc_q    <= oc_d;
            en_q    <= en_d;
            ov_q    <= ov_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.in_ready   = ir_q;
    assign bus.pipe_EN    = en_q;
    assign bus.pipe_vals0 = a_q;
    assign bus.pipe_vals1 = b_q;
    assign bus.out_valid  = ov_q;
    assign bus.out_data   = od_q;
    assign bus.out_count  = oc_q;

`ifdef SUMSQ_CTRL_PERF_EN
    logic [31:0] groups_q, groups_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        groups_d = groups_q;
        stall_d  = stall_q;
        if (state_q == S_OUT) begin
            if (bus.out_ready && groups_q != '1) groups_d = groups_q + 32'd1;
            if (!bus.out_ready && stall_q != '1) stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            groups_q <= '0;
            stall_q  <= '0;
        end else begin
            groups_q <= groups_d;
            stall_q  <= stall_d;
        end
    end

    assign perf_groups = groups_q;
    assign perf_stall  = stall_q;
`endif
endmodule

// File: tb/tb_pipes_sumsquare_ctrl.sv
// Scoreboard bench for pipes_sumsquare_ctrl: directed cases plus random groups against a grouping model.
module tb_pipes_sumsquare_ctrl;
    localparam int W  = 4;
    localparam int VW = 32;
    localparam int ST = 4;
    localparam int CW = $clog2(W + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipes_sumsquare_ctrl_if #(.WIDTH(W), .VARWIDTH(VW), .CW(CW)) bus ();
    pipes_sumsquare_ctrl_if #(.WIDTH(W), .VARWIDTH(VW), .CW(CW)) bus2 ();

`ifdef SUMSQ_CTRL_PERF_EN
    logic [31:0] pg, ps, pg2, ps2;
`endif

    pipes_sumsquare_ctrl #(.WIDTH(W), .VARWIDTH(VW), .SETTLE(ST), .CW(CW)) dut (
        .CLK(clk), .RST(rst), .bus(bus)
`ifdef SUMSQ_CTRL_PERF_EN
        , .perf_groups(pg), .perf_stall(ps)
`endif
    );

    pipes_sumsquare_ctrl #(.WIDTH(W), .VARWIDTH(VW), .SETTLE(1), .CW(CW)) dut2 (
        .CLK(clk), .RST(rst), .bus(bus2)
`ifdef SUMSQ_CTRL_PERF_EN
        , .perf_groups(pg2), .perf_stall(ps2)
`endif
    );

    // Exact int->float32 for values below 2^24.
    function automatic logic [31:0] i2f(input logic [31:0] v);
        int msb;
        logic [31:0] m;
        logic [7:0] e;
        if (v == 0) return 32'h0;
        msb = 0;
        for (int i = 0; i < 32; i++) if (v[i]) msb = i;
        m = v << (23 - msb);
        e = 8'(127 + msb);
        return {1'b0, e, m[22:0]};
    endfunction

    // Stand-in for the lane array: float32((a+b)^2) per lane.
    function automatic logic [W*VW-1:0] dp(input logic [W*VW-1:0] v0, input logic [W*VW-1:0] v1);
        logic [W*VW-1:0] r;
        logic [31:0] s;
        for (int i = 0; i < W; i++) begin
            s = v0[i*VW +: VW] + v1[i*VW +: VW];
            r[i*VW +: VW] = i2f(s * s);
        end
        return r;
    endfunction

    assign bus.pipe_out  = dp(bus.pipe_vals0, bus.pipe_vals1);
    assign bus2.pipe_out = dp(bus2.pipe_vals0, bus2.pipe_vals1);

    typedef struct {
        logic [W*VW-1:0] data;
        int              count;
        int              t_last;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] pa[$], pb[$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int beats = 0, hs = 0, rises = 0, exp_stall = 0, exp_groups = 0;
    bit seen = 0, prev_en = 0, prev_hs = 0, rnd_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: model groups from accepted beats, check every OUT cycle against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete(); pa.delete(); pb.delete();
            seen = 0; prev_hs = 0; prev_en = 0;
            exp_stall = 0; exp_groups = 0;
        end else begin
            if (bus.pipe_EN && !prev_en) rises++;
            prev_en = bus.pipe_EN;
            if (prev_hs) begin
                chk("ready_after_hs", 128'(bus.in_ready), 128'(1));
                chk("valid_after_hs", 128'(bus.out_valid), 128'(0));
            end
            prev_hs = 0;
            if (bus.in_valid && bus.in_ready) begin
                pa.push_back(bus.in_a);
                pb.push_back(bus.in_b);
                beats++;
                if (bus.in_last || pa.size() == W) begin
                    mon_e.data = '0;
                    for (int i = 0; i < pa.size(); i++)
                        mon_e.data[i*VW +: VW] = i2f((pa[i] + pb[i]) * (pa[i] + pb[i]));
                    mon_e.count  = pa.size();
                    mon_e.t_last = cyc + 1;
                    sb.push_back(mon_e);
                    pa.delete(); pb.delete();
                end
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_out: out_valid with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    mon_e = sb[0];
                    if (!seen) chk("latency", 128'(cyc - mon_e.t_last), 128'(ST + 2));
                    seen = 1;
                    chk("out_data", bus.out_data, mon_e.data);
                    chk("out_count", 128'(bus.out_count), 128'(mon_e.count));
                    chk("en_in_out", 128'(bus.pipe_EN), 128'(1));
                    chk("ready_in_out", 128'(bus.in_ready), 128'(0));
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        seen = 0; hs++; exp_groups++; prev_hs = 1;
                    end else begin
                        exp_stall++;
                    end
                end
            end
        end
    end

    // Random consumer backpressure, only while rnd_mode is set.
    initial forever begin
        @(posedge clk); #1;
        if (rnd_mode) bus.out_ready = ($urandom % 4) != 0;
    end

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
        int n = 0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_last = last;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: in_ready never rose (cycle %0d)", cyc);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic wait_ov();
        int n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            n_chk++; n_fail++;
            $display("FAIL wait_ov_timeout: out_valid never rose (cycle %0d)", cyc);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 1000) begin @(posedge clk); n++; end
        #1;
        if (n >= 1000) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d groups outstanding", sb.size());
        end
    endtask

    initial begin
        int r0, b0, h0, len, k;
        logic lst;
        bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_last = 0; bus.out_ready = 1;
        bus2.in_valid = 0; bus2.in_a = 0; bus2.in_b = 0; bus2.in_last = 0; bus2.out_ready = 1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_pipe_en", 128'(bus.pipe_EN), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        chk("rst_out_count", 128'(bus.out_count), 128'(0));
        chk("rst_out_data", bus.out_data, 128'(0));
        chk("rst_vals0", bus.pipe_vals0, 128'(0));
        @(posedge clk); #1 rst = 0;

        // Full group
        r0 = rises;
        for (int i = 1; i <= 4; i++) send_beat(32'(i), 32'(i), 1'b0);
        wait_ov();
        chk("t1_data", bus.out_data, {32'h42800000, 32'h42100000, 32'h41800000, 32'h40800000});
        chk("t1_count", 128'(bus.out_count), 128'(4));
        @(posedge clk); #1;
        drain();
        chk("t1_en_rises", 128'(rises - r0), 128'(1));

        // Partial group
        send_beat(32'd3, 32'd0, 1'b0);
        send_beat(32'd1, 32'd1, 1'b1);
        wait_ov();
        chk("t2_data", bus.out_data, {32'h0, 32'h0, 32'h40800000, 32'h41100000});
        chk("t2_count", 128'(bus.out_count), 128'(2));
        @(posedge clk); #1;
        drain();

        // Backpressure: 10 stalled OUT cycles
        bus.out_ready = 0;
        for (int i = 0; i < 4; i++) send_beat($urandom_range(0, 2047), $urandom_range(0, 2047), 1'b0);
        wait_ov();
        repeat (9) @(negedge clk);
        @(posedge clk); #1 bus.out_ready = 1;
        drain();
`ifdef SUMSQ_CTRL_PERF_EN
        chk("t3_perf_stall", 128'(ps), 128'(10));
`endif

        // Reset mid-SETTLE
        for (int i = 0; i < 4; i++) send_beat($urandom_range(1, 2047), $urandom_range(1, 2047), 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_rst_en", 128'(bus.pipe_EN), 128'(0));
        chk("t4_rst_valid", 128'(bus.out_valid), 128'(0));
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 4; i++) send_beat(32'd2, 32'd2, 1'b0);
        wait_ov();
        chk("t4_data", bus.out_data, {4{32'h41800000}});
        chk("t4_count", 128'(bus.out_count), 128'(4));
        @(posedge clk); #1;
        drain();

        // Back-to-back: three groups with in_valid held
        b0 = beats; h0 = hs;
        for (int i = 0; i < 12; i++) send_beat($urandom_range(0, 2047), $urandom_range(0, 2047), 1'b0);
        drain();
        chk("t5_beats", 128'(beats - b0), 128'(12));
        chk("t5_groups", 128'(hs - h0), 128'(3));

        // Random groups with random backpressure and gaps
        rnd_mode = 1;
        for (int g = 0; g < 25; g++) begin
            len = $urandom_range(1, W);
            for (int i = 0; i < len; i++) begin
                lst = (i == len - 1) && (len < W || ($urandom % 2) == 1);
                send_beat($urandom_range(0, 2047), $urandom_range(0, 2047), lst);
            end
            k = $urandom % 3;
            repeat (k) begin @(posedge clk); #1; end
        end
        drain();
        rnd_mode = 0;
        @(posedge clk); #1 bus.out_ready = 1;

        // SETTLE=1 instance: single beat with in_last
        bus2.in_valid = 1; bus2.in_a = 32'd5; bus2.in_b = 32'd6; bus2.in_last = 1;
        k = 0;
        @(negedge clk);
        while (!bus2.in_ready && k < 50) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        bus2.in_valid = 0; bus2.in_last = 0;
        k = 0;
        @(negedge clk);
        while (!bus2.out_valid && k < 20) begin @(negedge clk); k++; end
        chk("t6_latency", 128'(k), 128'(3));
        chk("t6_count", 128'(bus2.out_count), 128'(1));
        chk("t6_data", bus2.out_data, {32'h0, 32'h0, 32'h0, 32'h42F20000});
        @(posedge clk); #1;

        chk("end_sb_empty", 128'(sb.size()), 128'(0));
        chk("end_en_rises", 128'(rises), 128'(hs));
`ifdef SUMSQ_CTRL_PERF_EN
        chk("end_perf_groups", 128'(pg), 128'(exp_groups));
        chk("end_perf_stall", 128'(ps), 128'(exp_stall));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
